// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full_adder slice shared across all WIDTH bits, LSB first,
// with a registered carry between steps and a one-cycle done pulse per result.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] a_sh_r, a_sh_nxt_s;
  logic [WIDTH-1:0] b_sh_r, b_sh_nxt_s;
  logic [WIDTH-1:0] acc_r, acc_nxt_s;
  logic             c_r, c_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic [WIDTH-1:0] sum_r, sum_nxt_s;
  logic             cout_r, cout_nxt_s;
  logic             s_bit_s;
  logic             c_bit_s;

  full_adder u_slice (
    .a  (a_sh_r[0]),
    .b  (b_sh_r[0]),
    .ci (c_r),
    .s  (s_bit_s),
    .co (c_bit_s)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_nxt_s = state_r;
    a_sh_nxt_s  = a_sh_r;
    b_sh_nxt_s  = b_sh_r;
    acc_nxt_s   = acc_r;
    c_nxt_s     = c_r;
    cnt_nxt_s   = cnt_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    sum_nxt_s   = sum_r;
    cout_nxt_s  = cout_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          a_sh_nxt_s  = a;
          b_sh_nxt_s  = b;
          c_nxt_s     = cin;
          cnt_nxt_s   = {CNT_W{1'b0}};
          busy_nxt_s  = 1'b1;
          state_nxt_s = RUN;
        end else begin
          busy_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        acc_nxt_s  = {s_bit_s, acc_r[WIDTH-1:1]};
        a_sh_nxt_s = {1'b0, a_sh_r[WIDTH-1:1]};
        b_sh_nxt_s = {1'b0, b_sh_r[WIDTH-1:1]};
        c_nxt_s    = c_bit_s;
        cnt_nxt_s  = cnt_r + CNT_W'(1);
        // The final bit step publishes the result straight from the slice.
        if (cnt_r == CNT_LAST) begin
          sum_nxt_s   = {s_bit_s, acc_r[WIDTH-1:1]};
          cout_nxt_s  = c_bit_s;
          done_nxt_s  = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = IDLE;
      end
      default: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      c_r     <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      a_sh_r  <= a_sh_nxt_s;
      b_sh_r  <= b_sh_nxt_s;
      acc_r   <= acc_nxt_s;
      c_r     <= c_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      sum_r   <= sum_nxt_s;
      cout_r  <= cout_nxt_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq: 8-bit directed scenarios and a 16-bit random run.

module tb_serial_add_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = 8'h00, b8 = 8'h00;
  logic        cin8 = 1'b0;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = 16'h0000, b16 = 16'h0000;
  logic        cin16 = 1'b0;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  logic [8:0]  sb8[$];
  logic [16:0] sb16[$];
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  serial_add_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
  task automatic issue8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input bit push);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    if (push) sb8.push_back(9'(ta) + 9'(tb) + 9'(tc));
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
    a16 = ta; b16 = tb; cin16 = tc; start16 = 1'b1;
    sb16.push_back(17'(ta) + 17'(tb) + 17'(tc));
    @(negedge clk);
    start16 = 1'b0;
  endtask

  task automatic wait_done8(output int cyc);
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_done16(output int cyc);
    cyc = 0;
    while (done16 !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy8, done8, cout8, sum8} !== 11'h000) $display("FAIL reset_8 got %h want 000", {busy8, done8, cout8, sum8});
    else n_pass++;
    n_checks++;
    if ({busy16, done16, cout16, sum16} !== 19'h00000) $display("FAIL reset_16 got %h want 00000", {busy16, done16, cout16, sum16});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int busy_cnt = 0, done_cnt = 0, done_at = -1;
    logic [8:0] exp_v;
    issue8(8'h5A, 8'h3C, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (busy8) busy_cnt++;
      if (done8) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
        exp_v = (sb8.size() > 0) ? sb8.pop_front() : 9'h1FF;
        n_checks++;
        if ({cout8, sum8} !== exp_v) $display("FAIL basic_sum got %h want %h", {cout8, sum8}, exp_v);
        else n_pass++;
        n_checks++;
        if ({cout8, sum8} !== 9'h096) $display("FAIL basic_const got %h want 096", {cout8, sum8});
        else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (done_at !== 8) $display("FAIL basic_latency got %0d want 8", done_at); else n_pass++;
    n_checks++;
    if (busy_cnt !== 9) $display("FAIL basic_busy_cycles got %0d want 9", busy_cnt); else n_pass++;
    n_checks++;
    if (done_cnt !== 1) $display("FAIL basic_done_count got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_carry;
    int cyc;
    logic [8:0] exp_v;
    logic [8:0] lit[2];
    logic [7:0] av[2];
    logic [7:0] bv[2];
    logic       cv[2];
    lit[0] = 9'h100; av[0] = 8'hFF; bv[0] = 8'h01; cv[0] = 1'b0;
    lit[1] = 9'h1FF; av[1] = 8'hFF; bv[1] = 8'hFF; cv[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      issue8(av[k], bv[k], cv[k], 1'b1);
      wait_done8(cyc);
      exp_v = (sb8.size() > 0) ? sb8.pop_front() : 9'h000;
      n_checks++;
      if (cyc >= 40) $display("FAIL carry_timeout op %0d no done", k);
      else if ({cout8, sum8} !== exp_v || exp_v !== lit[k])
        $display("FAIL carry_sum op %0d got %h want %h", k, {cout8, sum8}, lit[k]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start;
    int done_cnt = 0;
    logic [8:0] exp_v;
    issue8(8'h10, 8'h20, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1; end
      if (i == 3 || i == 9) start8 = 1'b0;
      if (done8) begin
        done_cnt++;
        exp_v = (sb8.size() > 0) ? sb8.pop_front() : 9'h1FF;
        n_checks++;
        if ({cout8, sum8} !== exp_v) $display("FAIL ignore_sum got %h want %h", {cout8, sum8}, exp_v);
        else n_pass++;
        start8 = 1'b1;
      end
      @(negedge clk);
    end
    n_checks++;
    if (done_cnt !== 1) $display("FAIL ignore_done_count got %0d want 1", done_cnt); else n_pass++;
    n_checks++;
    if (busy8 !== 1'b0 || {cout8, sum8} !== 9'h030) $display("FAIL ignore_final got busy=%b res=%h want busy=0 res=030", busy8, {cout8, sum8});
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int done_cnt = 0, cyc;
    logic [8:0] exp_v;
    issue8(8'h7F, 8'h01, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy8, done8, cout8, sum8} !== 11'h000) $display("FAIL rst_async got %h want 000", {busy8, done8, cout8, sum8});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done8 || busy8) done_cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (done_cnt !== 0) $display("FAIL rst_no_done got %0d active cycles want 0", done_cnt); else n_pass++;
    issue8(8'h03, 8'h04, 1'b0, 1'b1);
    wait_done8(cyc);
    exp_v = (sb8.size() > 0) ? sb8.pop_front() : 9'h1FF;
    n_checks++;
    if (cyc >= 40) $display("FAIL rst_restart_timeout no done");
    else if ({cout8, sum8} !== exp_v || exp_v !== 9'h007) $display("FAIL rst_restart got %h want 007", {cout8, sum8});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int done_cnt = 0;
    int at[3];
    logic [8:0] exp_v;
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b1; start8 = 1'b1;
    for (int k = 0; k < 3; k++) sb8.push_back(9'h001 + 9'h001 + 9'h001);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      if (i == 25) start8 = 1'b0;
      if (done8) begin
        if (done_cnt < 3) at[done_cnt] = i;
        done_cnt++;
        exp_v = (sb8.size() > 0) ? sb8.pop_front() : 9'h1FF;
        n_checks++;
        if ({cout8, sum8} !== exp_v) $display("FAIL b2b_sum got %h want %h", {cout8, sum8}, exp_v);
        else n_pass++;
      end
      if (i == 13 || i == 23) begin
        n_checks++;
        if ({cout8, sum8} !== 9'h003) $display("FAIL b2b_stable cycle %0d got %h want 003", i, {cout8, sum8});
        else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (done_cnt !== 3) $display("FAIL b2b_count got %0d want 3", done_cnt);
    else if (at[1] - at[0] !== 10 || at[2] - at[1] !== 10)
      $display("FAIL b2b_spacing got %0d,%0d want 10,10", at[1] - at[0], at[2] - at[1]);
    else n_pass++;
  endtask

  task automatic test_random;
    int cyc;
    logic [16:0] exp_v;
    for (int n = 0; n < 1000; n++) begin
      issue16(16'($urandom), 16'($urandom), 1'($urandom));
      wait_done16(cyc);
      exp_v = (sb16.size() > 0) ? sb16.pop_front() : 17'h00000;
      n_checks++;
      if (cyc >= 60) begin
        $display("FAIL rand_timeout op %0d no done", n);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end else if ({cout16, sum16} !== exp_v)
        $display("FAIL rand_sum op %0d got %h want %h", n, {cout16, sum16}, exp_v);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
